// File: rtl/param_bank_pkg.sv
// param_bank_pkg: shared state type, swap counter width and bank-address helper.
package param_bank_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, COPY} param_seq_state_t;

    localparam int SWAP_COUNT_WIDTH = 8;

    function automatic logic [31:0] bank_addr(logic bank, logic [31:0] addr, int aw);
        return (32'(bank) << aw) | addr;
    endfunction

endpackage

// File: rtl/param_bank_sequencer_if.sv
// param_bank_sequencer_if: SPI parameter port and parameter RAM port bundle.
interface param_bank_sequencer_if #(
    parameter int PARAM_WIDTH = 36,
    parameter int ADDR_WIDTH  = 8
);
    logic [ADDR_WIDTH-1:0]  spi_wr_addr;
    logic [PARAM_WIDTH-1:0] spi_wr_data;
    logic                   spi_wr_enable;
    logic [ADDR_WIDTH-1:0]  spi_rd_addr;
    logic [PARAM_WIDTH-1:0] spi_rd_data;
    logic [ADDR_WIDTH:0]    ram_a_addr;
    logic [ADDR_WIDTH:0]    ram_b_addr;
    logic [PARAM_WIDTH-1:0] ram_b_data;
    logic [ADDR_WIDTH:0]    ram_wr_addr;
    logic [PARAM_WIDTH-1:0] ram_wr_data;
    logic                   ram_wr_en;

    modport slave (
        input  spi_wr_addr, spi_wr_data, spi_wr_enable, spi_rd_addr, ram_b_data,
        output spi_rd_data, ram_a_addr, ram_b_addr, ram_wr_addr, ram_wr_data, ram_wr_en
    );

    modport master (
        output spi_wr_addr, spi_wr_data, spi_wr_enable, spi_rd_addr, ram_b_data,
        input  spi_rd_data, ram_a_addr, ram_b_addr, ram_wr_addr, ram_wr_data, ram_wr_en
    );
endinterface

// File: rtl/param_copy_engine.sv
// param_copy_engine: active-to-shadow copy pointer, dirty bitmap and one-entry
// stall buffer; SPI writes always win over the copy.
module param_copy_engine import param_bank_pkg::*; #(
    parameter int PARAM_WIDTH = 36,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   active,
    input  logic                   hold,
    input  logic                   spi_wr,
    input  logic [ADDR_WIDTH-1:0]  spi_addr,
    input  logic [PARAM_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0]  ptr,
    output logic                   copy_we,
    output logic [ADDR_WIDTH-1:0]  copy_addr,
    output logic [PARAM_WIDTH-1:0] copy_data,
    output logic                   done
);
    logic [2**ADDR_WIDTH-1:0] dirty;
    logic                     reads_done, rd_valid, buf_valid;
    logic [ADDR_WIDTH-1:0]    rd_addr, buf_addr;
    logic [PARAM_WIDTH-1:0]   buf_data;
    logic                     cand_valid, skip, wants, to_buf, grant;

    // a word already rewritten by SPI is never overwritten by the copy
    always_comb begin
        cand_valid = buf_valid | rd_valid;
        copy_addr  = buf_valid ? buf_addr : rd_addr;
        copy_data  = buf_valid ? buf_data : rd_data;
        skip       = dirty[copy_addr] | (spi_wr && spi_addr == copy_addr);
        wants      = cand_valid & ~skip;
        to_buf     = wants & spi_wr;
        copy_we    = wants & ~spi_wr;
        grant      = active & ~reads_done & ~hold & ~to_buf;
        done       = active & cand_valid & ~to_buf & (copy_addr == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty      <= '0;
            ptr        <= '0;
            reads_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
        end else if (start) begin
            dirty      <= '0;
            ptr        <= '0;
            reads_done <= 1'b0;
            rd_valid   <= 1'b0;
            buf_valid  <= 1'b0;
        end else begin
            rd_valid  <= grant;
            rd_addr   <= ptr;
            buf_valid <= to_buf;
            if (grant) begin
                ptr        <= ptr + 1'b1;
                reads_done <= reads_done | (ptr == '1);
            end
            if (to_buf) begin
                buf_addr <= copy_addr;
                buf_data <= copy_data;
            end
            if (active && spi_wr)
                dirty[spi_addr] <= 1'b1;
        end
    end
endmodule

// File: rtl/param_bank_sequencer.sv
// param_bank_sequencer: double-buffered parameter store with frame-aligned bank swap.
// Optional SWAP_COUNT_EN adds an 8-bit wrapping swap_count output.
module param_bank_sequencer import param_bank_pkg::*; #(
    parameter int PARAM_WIDTH = 36,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    param_bank_sequencer_if.slave bus,
    input  logic                  commit_req,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] dsp_rd_addr,
    output logic                  active_bank,
    output logic                  busy
`ifdef SWAP_COUNT_EN
    ,
    output logic [SWAP_COUNT_WIDTH-1:0] swap_count
`endif
);
    param_seq_state_t      state;
    logic                  pending, served, spi_sel, copy_we, done;
    logic [ADDR_WIDTH-1:0] rd_addr_q, ptr, copy_addr;
    logic [PARAM_WIDTH-1:0] copy_data;

    function automatic logic [ADDR_WIDTH:0] ba(logic b, logic [ADDR_WIDTH-1:0] a);
        return (ADDR_WIDTH+1)'(bank_addr(b, 32'(a), ADDR_WIDTH));
    endfunction

    // SPI readback steals port B only in the cycle its address changes during COPY
    assign spi_sel = state != COPY || bus.spi_rd_addr != rd_addr_q;

    param_copy_engine #(.PARAM_WIDTH(PARAM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_copy (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state == WAIT_FRAME && frame_start),
        .active   (state == COPY),
        .hold     (spi_sel),
        .spi_wr   (bus.spi_wr_enable),
        .spi_addr (bus.spi_wr_addr),
        .rd_data  (bus.ram_b_data),
        .ptr      (ptr),
        .copy_we  (copy_we),
        .copy_addr(copy_addr),
        .copy_data(copy_data),
        .done     (done)
    );

    assign bus.ram_a_addr  = ba(active_bank, dsp_rd_addr);
    assign bus.ram_b_addr  = ba(active_bank, spi_sel ? bus.spi_rd_addr : ptr);
    assign bus.ram_wr_en   = bus.spi_wr_enable | copy_we;
    assign bus.ram_wr_addr = ba(~active_bank, bus.spi_wr_enable ? bus.spi_wr_addr : copy_addr);
    assign bus.ram_wr_data = bus.spi_wr_enable ? bus.spi_wr_data : copy_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pending         <= 1'b0;
            active_bank     <= 1'b0;
            busy            <= 1'b0;
            served          <= 1'b0;
            rd_addr_q       <= '0;
            bus.spi_rd_data <= '0;
`ifdef SWAP_COUNT_EN
            swap_count      <= '0;
`endif
        end else begin
            rd_addr_q <= bus.spi_rd_addr;
            served    <= spi_sel;
            if (served)
                bus.spi_rd_data <= bus.ram_b_data;
            case (state)
                IDLE: if (commit_req || pending) begin
                    state   <= WAIT_FRAME;
                    pending <= 1'b0;
                    busy    <= 1'b1;
                end
                WAIT_FRAME: if (frame_start) begin
                    state       <= COPY;
                    active_bank <= ~active_bank;
`ifdef SWAP_COUNT_EN
                    swap_count  <= swap_count + 1'b1;
`endif
                end
                COPY: begin
                    if (commit_req)
                        pending <= 1'b1;
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_bank_sequencer.sv
// tb_param_bank_sequencer: randomized bench with a RAM, and a two-array bank model.
module tb_param_bank_sequencer;
    import param_bank_pkg::*;
    localparam int PW = 36;
    localparam int AW = 8;
    localparam int D  = 256;

    logic clk = 0, rst_n = 0, commit_req = 0, frame_start = 0;
    logic [AW-1:0] dsp_rd_addr = '0;
    logic active_bank, busy;
`ifdef SWAP_COUNT_EN
    logic [7:0] swap_count;
`endif

    param_bank_sequencer_if #(.PARAM_WIDTH(PW), .ADDR_WIDTH(AW)) bus();

    param_bank_sequencer #(.PARAM_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .commit_req(commit_req),
        .frame_start(frame_start), .dsp_rd_addr(dsp_rd_addr),
        .active_bank(active_bank), .busy(busy)
`ifdef SWAP_COUNT_EN
        , .swap_count(swap_count)
`endif
    );

    always #5 clk = ~clk;

    logic [PW-1:0] mem [0:2*D-1];
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        bus.ram_b_data <= mem[bus.ram_b_addr];
    end

    // model: what the DSP sees and what the shadow must hold once the copy is done
    logic [PW-1:0] ref_act [D];
    logic [PW-1:0] ref_sh  [D];
    logic ref_bank = 0;
    int ref_swaps = 0;
    int tests = 0, fails = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic spi_write(input logic [AW-1:0] a, input logic [PW-1:0] d);
        bus.spi_wr_addr = a; bus.spi_wr_data = d; bus.spi_wr_enable = 1;
        tick();
        bus.spi_wr_enable = 0;
        ref_sh[a] = d;
    endtask

    task automatic commit();
        commit_req = 1; tick(); commit_req = 0;
    endtask

    task automatic swap_frame(input string tag);
        frame_start = 1; tick(); frame_start = 0;
        for (int a = 0; a < D; a++) ref_act[a] = ref_sh[a];
        ref_bank = ~ref_bank;
        ref_swaps++;
        tests++;
        if (active_bank !== ref_bank) begin
            fails++; $display("FAIL %s toggle: active_bank=%0b want %0b", tag, active_bank, ref_bank);
        end
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        tests++;
        if (busy) begin fails++; $display("FAIL %s busy timeout after %0d cycles", tag, n); end
    endtask

    task automatic check_banks(input string tag);
        logic [AW:0] ia, is;
        for (int a = 0; a < D; a++) begin
            ia = {ref_bank, AW'(a)};
            is = {~ref_bank, AW'(a)};
            tests += 2;
            if (mem[ia] !== ref_act[a]) begin
                fails++; $display("FAIL %s active[%0d]=%h want %h", tag, a, mem[ia], ref_act[a]);
            end
            if (mem[is] !== ref_sh[a]) begin
                fails++; $display("FAIL %s shadow[%0d]=%h want %h", tag, a, mem[is], ref_sh[a]);
            end
        end
    endtask

    task automatic rand_addr(input logic [AW-1:0] avoid, output logic [AW-1:0] a);
        a = AW'($urandom_range(0, D-1));
        if (a == avoid) a = a + 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests += 4;
        if (active_bank !== 1'b0) begin fails++; $display("FAIL reset active_bank=%0b want 0", active_bank); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset busy=%0b want 0", busy); end
        if (bus.spi_rd_data !== '0) begin fails++; $display("FAIL reset spi_rd_data=%h want 0", bus.spi_rd_data); end
        if (bus.ram_wr_en !== 1'b0) begin fails++; $display("FAIL reset ram_wr_en=%0b want 0", bus.ram_wr_en); end
`ifdef SWAP_COUNT_EN
        tests++;
        if (swap_count !== 8'd0) begin fails++; $display("FAIL reset swap_count=%0d want 0", swap_count); end
`endif
        rst_n = 1;
        tick();
        dsp_rd_addr = 8'd5;
        #1;
        tests++;
        if (bus.ram_a_addr !== 9'h005) begin fails++; $display("FAIL reset ram_a_addr=%h want 005", bus.ram_a_addr); end
    endtask

    task automatic test_first_swap();
        logic [AW-1:0] a;
        int n;
        spi_write(8'd3, 36'h123456789);
        for (int i = 0; i < 5; i++) begin rand_addr(8'd3, a); spi_write(a, PW'({$urandom, $urandom})); end
        commit();
        repeat (9) tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL first busy_wait=%0b want 1", busy); end
        swap_frame("first");
        dsp_rd_addr = 8'd3;
        #1;
        tests += 2;
        if (bus.ram_a_addr !== 9'h103) begin fails++; $display("FAIL first ram_a_addr=%h want 103", bus.ram_a_addr); end
        if (mem[bus.ram_a_addr] !== 36'h123456789) begin
            fails++; $display("FAIL first dsp_read=%h want 123456789", mem[bus.ram_a_addr]);
        end
        wait_idle("first", n);
        tests++;
        if (n != 257) begin fails++; $display("FAIL first copy_cycles=%0d want 257", n); end
        check_banks("first");
    endtask

    task automatic test_write_during_copy();
        logic [AW-1:0] a;
        int n;
        for (int i = 0; i < 8; i++) begin rand_addr(8'd200, a); spi_write(a, PW'({$urandom, $urandom})); end
        commit();
        tick();
        swap_frame("wcopy");
        repeat (49) tick();
        spi_write(8'd200, 36'hABC);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 8)) tick();
            rand_addr(8'd200, a);
            spi_write(a, PW'({$urandom, $urandom}));
        end
        wait_idle("wcopy", n);
        tests++;
        if (mem[{~ref_bank, 8'd200}] !== 36'hABC) begin
            fails++; $display("FAIL wcopy shadow200=%h want abc", mem[{~ref_bank, 8'd200}]);
        end
        check_banks("wcopy");
    endtask

    task automatic test_read_during_copy();
        logic [AW-1:0] a;
        int n, nchg;
        a = AW'($urandom_range(0, D-1));
        bus.spi_rd_addr = a;
        tick(); tick();
        tests++;
        if (bus.spi_rd_data !== ref_act[a]) begin
            fails++; $display("FAIL rd_idle data=%h want %h", bus.spi_rd_data, ref_act[a]);
        end
        commit();
        tick();
        swap_frame("rcopy");
        nchg = $urandom_range(4, 8);
        n = 0;
        for (int k = 0; k < nchg; k++) begin
            repeat (15) begin tick(); n++; end
            a = a + AW'($urandom_range(1, D-1));
            bus.spi_rd_addr = a;
            tick(); n++;
            tick(); n++;
            tests++;
            if (bus.spi_rd_data !== ref_act[a]) begin
                fails++; $display("FAIL rd_copy addr %0d data=%h want %h", a, bus.spi_rd_data, ref_act[a]);
            end
        end
        while (busy && n < 3000) begin tick(); n++; end
        tests++;
        if (n != 257 + nchg) begin fails++; $display("FAIL rd_copy copy_cycles=%0d want %0d", n, 257 + nchg); end
        check_banks("rcopy");
    endtask

    task automatic test_commit_during_copy();
        int n;
        logic prev;
        commit();
        repeat (3) tick();
        swap_frame("pend1");
        repeat ($urandom_range(10, 200)) tick();
        commit();
        wait_idle("pend1", n);
        prev = active_bank;
        tick();
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL pend busy=%0b want 1", busy); end
        if (active_bank !== ref_bank) begin fails++; $display("FAIL pend early_toggle=%0b want %0b", active_bank, ref_bank); end
        check_banks("pend1");
        repeat (5) tick();
        tests++;
        if (active_bank !== prev) begin fails++; $display("FAIL pend wait_toggle=%0b want %0b", active_bank, prev); end
        swap_frame("pend2");
        wait_idle("pend2", n);
        check_banks("pend2");
`ifdef SWAP_COUNT_EN
        tests++;
        if (swap_count !== 8'(ref_swaps)) begin fails++; $display("FAIL pend swap_count=%0d want %0d", swap_count, ref_swaps); end
`endif
    endtask

    task automatic test_absorb();
        int n;
        commit();
        tick();
        commit();
        tick();
        swap_frame("absorb");
        wait_idle("absorb", n);
        repeat (5) tick();
        tests += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL absorb busy=%0b want 0", busy); end
        if (active_bank !== ref_bank) begin fails++; $display("FAIL absorb active_bank=%0b want %0b", active_bank, ref_bank); end
        frame_start = 1; tick(); frame_start = 0;
        tests++;
        if (active_bank !== ref_bank) begin fails++; $display("FAIL idle_frame active_bank=%0b want %0b", active_bank, ref_bank); end
    endtask

    task automatic test_reset_mid_copy();
        commit();
        tick();
        swap_frame("rstmid");
        repeat (30) tick();
        rst_n = 0;
        #1;
        ref_bank = 0;
        ref_swaps = 0;
        tests += 2;
        if (active_bank !== 1'b0) begin fails++; $display("FAIL rstmid active_bank=%0b want 0", active_bank); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rstmid busy=%0b want 0", busy); end
`ifdef SWAP_COUNT_EN
        tests++;
        if (swap_count !== 8'd0) begin fails++; $display("FAIL rstmid swap_count=%0d want 0", swap_count); end
`endif
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        bus.spi_wr_addr = '0; bus.spi_wr_data = '0; bus.spi_wr_enable = 0; bus.spi_rd_addr = '0;
        for (int i = 0; i < 2*D; i++) mem[i] = PW'({$urandom, $urandom});
        for (int a = 0; a < D; a++) begin ref_act[a] = mem[a]; ref_sh[a] = mem[D+a]; end
        test_reset();
        test_first_swap();
        test_write_during_copy();
        test_read_during_copy();
        test_commit_during_copy();
        test_absorb();
        test_reset_mid_copy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
